// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS-7 types, constants and LFSR step function
package prbs_pkg;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  // s[n] = s[n-TAP_A] xor s[n-TAP_B]
  localparam int TAP_A = 7;
  localparam int TAP_B = 6;
  localparam int MAX_W = 32;
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  // state[0] is the oldest of the last 7 sequence bits, state[6] the newest
  typedef struct packed {
    logic [6:0]       state;
    logic [MAX_W-1:0] beat;
  } prbs_step_t;

  // Generate the next w bits (bit 0 earliest) and the state after them
  function automatic prbs_step_t prbs7_next(input logic [6:0] state, input int w);
    prbs_step_t r;
    logic       nb;
    r.state = state;
    r.beat  = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        nb        = r.state[7-TAP_A] ^ r.state[7-TAP_B];
        r.beat[i] = nb;
        r.state   = {nb, r.state[6:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// rtl/prbs_checker_if.sv - beat input and error-report bundle for prbs_checker
interface prbs_checker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int EB = $clog2(WIDTH + 1);

  logic             valid_in;
  logic [WIDTH-1:0] data_in;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [EB-1:0]    err_bits;
  logic [CNT_W-1:0] err_count;

  modport master (
    output valid_in, data_in, clear,
    input  locked, err_pulse, err_bits, err_count
  );

  modport slave (
    input  valid_in, data_in, clear,
    output locked, err_pulse, err_bits, err_count
  );
endinterface

// File: rtl/prbs7_advance.sv
// rtl/prbs7_advance.sv - combinational WIDTH-step PRBS-7 unroll
module prbs7_advance
  import prbs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [6:0]       state,
  output logic [WIDTH-1:0] beat,
  output logic [6:0]       next_state
);

  prbs_step_t step;
  logic       unused_beat_hi;

  // Unroll WIDTH serial LFSR steps from the current state
  always_comb begin
    step = prbs7_next(state, WIDTH);
  end

  assign beat           = step.beat[WIDTH-1:0];
  assign next_state     = step.state;
  assign unused_beat_hi = ^step.beat;

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising parallel PRBS-7 receive checker
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  prbs_checker_if.slave bus
);

  localparam int EB = $clog2(WIDTH + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
  localparam logic [BW-1:0] LOSS_V = BW'(LOSS_CNT);

  state_t           state;
  logic [6:0]       pred;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_cnt;
  logic             locked_q;
  logic             err_pulse_q;
  logic [EB-1:0]    err_bits_q;
  logic [CNT_W-1:0] err_count_q;

  logic [WIDTH-1:0] exp_beat;
  logic [WIDTH-1:0] diff;
  logic [6:0]       pred_next;
  logic [6:0]       seed;
  logic             match;
  logic [EB-1:0]    pop;
  logic             bad_beat;

  prbs7_advance #(.WIDTH(WIDTH)) u_advance (
    .state      (pred),
    .beat       (exp_beat),
    .next_state (pred_next)
  );

  // The newest 7 bits of a beat form the seed for the following beat
  assign seed     = bus.data_in[WIDTH-1:WIDTH-7];
  assign match    = (bus.data_in == exp_beat);
  assign bad_beat = bus.valid_in && (state == LOCKED) && !match;

  // Count the bit positions that differ from the prediction
  always_comb begin
    diff = bus.data_in ^ exp_beat;
    pop  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + EB'(diff[i]);
    end
  end

  // Lock FSM, predictor and registered error reporting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HUNT;
      pred        <= PRBS_SEED;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_bits_q  <= '0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      err_bits_q  <= '0;
      if (bus.valid_in) begin
        case (state)
          HUNT: begin
            // A zero seed would lock onto a stuck-zero stream
            if (seed != 7'd0) begin
              pred     <= seed;
              good_cnt <= '0;
              state    <= VERIFY;
            end
          end
          VERIFY: begin
            if (match) begin
              pred     <= pred_next;
              good_cnt <= good_cnt + 1'b1;
              if (good_cnt + 1'b1 == LOCK_V) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                bad_cnt  <= '0;
              end
            end else begin
              pred     <= seed;
              good_cnt <= '0;
              if (seed == 7'd0) state <= HUNT;
            end
          end
          LOCKED: begin
            // Free-run from the prediction so bad data cannot corrupt it
            pred <= pred_next;
            if (!match) begin
              err_pulse_q <= 1'b1;
              err_bits_q  <= pop;
              bad_cnt     <= bad_cnt + 1'b1;
              if (bad_cnt + 1'b1 == LOSS_V) begin
                state    <= HUNT;
                locked_q <= 1'b0;
              end
            end else begin
              bad_cnt <= '0;
            end
          end
          default: state <= HUNT;
        endcase
      end
      if (bus.clear) begin
        err_count_q <= '0;
      end else if (bad_beat && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_bits  = err_bits_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - self-checking bench for prbs_checker
module tb_prbs_checker;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prbs_checker_if #(.WIDTH(W), .CNT_W(16)) bus16 ();
  prbs_checker_if #(.WIDTH(W), .CNT_W(4))  bus4 ();

  prbs_checker #(.WIDTH(W), .LOCK_CNT(4), .LOSS_CNT(4), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus16.slave)
  );
  prbs_checker #(.WIDTH(W), .LOCK_CNT(4), .LOSS_CNT(4), .CNT_W(4)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4.slave)
  );

  int total = 0;
  int bad   = 0;

  // stream generator and reference model: sequences kept as bit queues, oldest first
  bit gq[$];
  bit mq[$];
  bit mq_next[$];
  int m_mode, m_good, m_bad, m_cnt, m_bits;
  bit m_locked, m_pulse;

  typedef struct {
    bit         v;
    logic [7:0] flip;
    bit         clr;
    bit         locked;
    bit         pulse;
    int         bits;
    int         cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gen_beat();
    logic [W-1:0] r;
    bit b;
    for (int j = 0; j < W; j++) begin
      b = gq[0] ^ gq[1];
      gq.push_back(b);
      void'(gq.pop_front());
      r[j] = b;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_exp();
    logic [W-1:0] r;
    bit t[$];
    bit b;
    t = mq;
    for (int j = 0; j < W; j++) begin
      b = t[0] ^ t[1];
      t.push_back(b);
      void'(t.pop_front());
      r[j] = b;
    end
    mq_next = t;
    return r;
  endfunction

  task automatic model_load(input logic [W-1:0] d);
    mq.delete();
    for (int j = W - 7; j < W; j++) mq.push_back(d[j]);
  endtask

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_bits = 0;
    m_locked = 0; m_pulse = 0;
    mq.delete();
    for (int j = 0; j < 7; j++) mq.push_back(1'b1);
  endtask

  task automatic model_update(input bit v, input logic [W-1:0] d, input bit c);
    logic [W-1:0] e;
    m_pulse = 0;
    m_bits  = 0;
    if (v) begin
      case (m_mode)
        0: if (d[W-1:W-7] != 7'd0) begin
          model_load(d); m_good = 0; m_mode = 1;
        end
        1: begin
          e = model_exp();
          if (d == e) begin
            mq = mq_next;
            m_good++;
            if (m_good == 4) begin m_mode = 2; m_bad = 0; m_locked = 1; end
          end else begin
            model_load(d);
            m_good = 0;
            if (d[W-1:W-7] == 7'd0) m_mode = 0;
          end
        end
        default: begin
          e  = model_exp();
          mq = mq_next;
          if (d != e) begin
            m_pulse = 1;
            m_bits  = $countones(d ^ e);
            m_cnt++;
            m_bad++;
            if (m_bad == 4) begin m_mode = 0; m_locked = 0; end
          end else begin
            m_bad = 0;
          end
        end
      endcase
    end
    if (c) m_cnt = 0;
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit c);
    bus16.valid_in = v; bus16.data_in = d; bus16.clear = c;
    bus4.valid_in  = v; bus4.data_in  = d; bus4.clear  = c;
  endtask

  task automatic step(input bit v, input logic [W-1:0] d, input bit c);
    drive(v, d, c);
    @(posedge clk);
    model_update(v, d, c);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".locked"}, 32'(bus16.locked), 32'(m_locked));
    chk({tag, ".pulse"}, 32'(bus16.err_pulse), 32'(m_pulse));
    chk({tag, ".bits"}, 32'(bus16.err_bits), 32'(m_bits));
    chk({tag, ".cnt16"}, 32'(bus16.err_count), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
    chk({tag, ".cnt4"}, 32'(bus4.err_count), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".locked"}, 32'(bus16.locked), 0);
    chk({tag, ".pulse"}, 32'(bus16.err_pulse), 0);
    chk({tag, ".bits"}, 32'(bus16.err_bits), 0);
    chk({tag, ".cnt16"}, 32'(bus16.err_count), 0);
    chk({tag, ".cnt4"}, 32'(bus4.err_count), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, '0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] f;
    int r;
    int burst;

    for (int j = 0; j < 7; j++) gq.push_back(1'b1);
    do_reset();
    check_zero("reset");

    // directed table: lock, single error, inverted burst with gap, relock, clear
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 8'h00, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 8'h08, 0, 1, 1, 1, 1});
    tbl.push_back('{1, 8'h00, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 8'hFF, 0, 1, 1, 8, 2});
    tbl.push_back('{1, 8'hFF, 0, 1, 1, 8, 3});
    tbl.push_back('{0, 8'h00, 0, 1, 0, 0, 3});
    tbl.push_back('{1, 8'hFF, 0, 1, 1, 8, 4});
    tbl.push_back('{1, 8'hFF, 0, 0, 1, 8, 5});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 5});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 5});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 5});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 5});
    tbl.push_back('{1, 8'h00, 0, 1, 0, 0, 5});
    tbl.push_back('{1, 8'h01, 0, 1, 1, 1, 6});
    tbl.push_back('{1, 8'h00, 0, 1, 0, 0, 6});
    tbl.push_back('{1, 8'h80, 0, 1, 1, 1, 7});
    tbl.push_back('{1, 8'h00, 0, 1, 0, 0, 7});
    tbl.push_back('{1, 8'h10, 1, 1, 1, 1, 0});
    tbl.push_back('{1, 8'h00, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 8'h03, 0, 1, 1, 2, 1});
    tbl.push_back('{1, 8'h00, 1, 1, 0, 0, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      d = tbl[i].v ? (gen_beat() ^ tbl[i].flip) : W'($urandom);
      step(tbl[i].v, d, tbl[i].clr);
      chk($sformatf("tbl%0d.locked", i), 32'(bus16.locked), 32'(tbl[i].locked));
      chk($sformatf("tbl%0d.pulse", i), 32'(bus16.err_pulse), 32'(tbl[i].pulse));
      chk($sformatf("tbl%0d.bits", i), 32'(bus16.err_bits), 32'(tbl[i].bits));
      chk($sformatf("tbl%0d.cnt", i), 32'(bus16.err_count), 32'(tbl[i].cnt));
    end

    // stuck-zero stream must never lock, then a clean stream locks after 5 beats
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, '0, 0);
      chk("zero.locked", 32'(bus16.locked), 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, gen_beat(), 0);
      chk("zlock.locked", 32'(bus16.locked), (i == 4) ? 1 : 0);
    end
    chk("zlock.cnt", 32'(bus16.err_count), 0);

    // saturation: 20 single-bit errors interleaved with good beats
    for (int i = 0; i < 20; i++) begin
      step(1, gen_beat() ^ W'(1 << $urandom_range(0, W - 1)), 0);
      check_model("sat_err");
      step(1, gen_beat(), 0);
      check_model("sat_ok");
    end
    chk("sat.cnt4", 32'(bus4.err_count), 15);
    chk("sat.cnt16", 32'(bus16.err_count), 20);

    // asynchronous reset while locked with err_count=3 and err_pulse high
    step(1, gen_beat(), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, gen_beat(), 0);
      step(1, gen_beat() ^ 8'h04, 0);
    end
    chk("pre_rst.cnt", 32'(bus16.err_count), 3);
    chk("pre_rst.pulse", 32'(bus16.err_pulse), 1);
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    drive(1, gen_beat(), 0);
    @(negedge clk);
    check_zero("rst_held");
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, W'($urandom), 0);
      check_model("gap");
      step(1, gen_beat(), 0);
      check_model("relock");
    end
    chk("relock.locked", 32'(bus16.locked), 1);

    // randomized stream against the reference model
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 2) begin
        gq.delete();
        d = '0;
        while (d[6:0] == 7'd0) d = W'($urandom);
        for (int j = 0; j < 7; j++) gq.push_back(d[j]);
      end else if (r < 4) begin
        burst = 5;
      end
      if ($urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 99);
        if (burst > 0) begin f = '1; burst--; end
        else if (r < 8) f = W'(1 << $urandom_range(0, W - 1));
        else if (r < 12) f = W'($urandom);
        else f = '0;
        step(1, gen_beat() ^ f, $urandom_range(0, 49) == 0);
      end else begin
        step(0, W'($urandom), $urandom_range(0, 49) == 0);
      end
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side checker for a parallel PRBS-7 test stream. Samples a WIDTH-bit beat on each valid cycle, self-synchronises to the incoming sequence, then counts beat and bit errors against its own predicted sequence. It sits downstream of the DUT in self-checking benches and BIST paths, as the counterpart to the random/PRBS stimulus side.

## Interface
- WIDTH, 8, bits per beat; legal range 7..32.
- LOCK_CNT, 4, consecutive matching beats required in VERIFY before LOCKED.
- LOSS_CNT, 4, consecutive mismatching beats in LOCKED before returning to HUNT.
- CNT_W, 16, width of err_count.
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- valid_in  input  1  data_in carries a beat this cycle.
- data_in  input  WIDTH  beat; bit 0 is the earliest bit in sequence time.
- clear  input  1  synchronous; zeroes err_count.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatching beat while LOCKED.
- err_bits  output  $clog2(WIDTH+1)  popcount of mismatching bits for that beat; 0 when err_pulse is low.
- err_count  output  CNT_W  saturating count of mismatching beats while LOCKED.

## Operation
- Sequence: serial PRBS-7 is s[n] = s[n-7] xor s[n-6]. Beat k holds s[kW .. kW+W-1].
- Predictor state: the last 7 sequence bits. Expected beat = next W bits generated from that state.
- All state changes only on cycles with valid_in=1. valid_in=0 holds every register, and err_pulse is low.
- HUNT: on a valid beat, load the predictor from data_in[W-1:W-7], clear good_cnt, and go to VERIFY.
- VERIFY: compare the beat with the expected value.
  - Match: good_cnt++ and advance the predictor. When good_cnt reaches LOCK_CNT, go to LOCKED.
  - Mismatch: reseed from this beat, set good_cnt=0, and stay in VERIFY.
  - No errors are counted in this state.
- LOCKED: the predictor advances from its own expected bits, so received errors never corrupt it.
  - Mismatch: err_pulse=1, err_bits=popcount(data_in xor expected), err_count+1 saturating at 2^CNT_W-1, and bad_cnt++.
  - Match: bad_cnt=0.
  - When bad_cnt reaches LOSS_CNT, go to HUNT with locked low. Counters are not cleared.
- clear: sets err_count=0. If it coincides with an error beat, clear wins and err_count=0, but err_pulse and err_bits still report that beat.
- An all-zero predictor state (a stuck-zero stream) never matches non-zero data. A zero stream in VERIFY keeps reseeding to zero and "matches". Therefore an all-zero seed is rejected: the block stays in HUNT.

## Timing
- Reset values: locked=0, err_pulse=0, err_bits=0, err_count=0, state HUNT, good_cnt=0, bad_cnt=0, predictor 7'h7F.
- All outputs are registered, with a 1-cycle latency from the sampled beat to err_pulse, err_bits and err_count.
- locked rises the cycle after the LOCK_CNT-th matching VERIFY beat. With the defaults, that is 1 seed beat plus 4 beats, so locked is first high after the 5th valid beat.
- locked falls the cycle after the LOSS_CNT-th consecutive bad beat.
- Reset asserted mid-operation returns everything to reset values immediately, with no clock edge required.

## Structure
- Package prbs_pkg:
  - state enum {HUNT, VERIFY, LOCKED}.
  - PRBS-7 taps constant (7, 6).
  - Function prbs7_next(state, W), returning the W-bit expected beat and the next state.
  - The package is shared with the future PRBS generator.
- Sub-module prbs7_advance: combinational W-step LFSR unroll, used once here and later reused by the generator.
- Popcount stays inline as a for-loop.

## Test plan
- Clean stream, WIDTH=8, seed 7'h7F, 10 beats: locked=1 from the cycle after beat 5, err_count=0, err_pulse never high.
- Clean lock, then flip bit 3 of beat 20: a single err_pulse with err_bits=1, err_count=1, locked stays 1, and beats 21 onward match.
- Clean lock, then 4 consecutive beats inverted: err_count=4, each err_bits=8, locked falls after the 4th bad beat. The stream then resumes clean and relocks after 5 beats.
- CNT_W=4, locked, 20 single-bit-error beats interleaved with good beats: err_count saturates at 15 and holds.
- clear asserted on the same cycle as an error beat with err_count=7: err_count=0 next cycle and err_pulse=1.
- Reset driven low while locked with err_count=3, and valid_in held with gaps: all outputs are 0 immediately, and state is HUNT after reset release. valid_in=0 cycles change nothing.
